// File: rtl/timer_counter.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT word registers and a four-state
// FSM that loads PRESET, counts down to zero and raises a level interrupt.
module timer_counter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  localparam logic [1:0] OFS_CTRL    = 2'd0;
  localparam logic [1:0] OFS_PRESET  = 2'd1;
  localparam logic [1:0] OFS_COUNT   = 2'd2;
  localparam logic [1:0] MODE_RELOAD = 2'b01;

  state_t      r_state;
  logic [3:0]  r_ctrl;       // {IM, MODE[1:0], EN}
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_irq_flag;

  logic        w_en;
  logic [1:0]  w_mode;
  logic        w_im;
  logic [1:0]  w_ofs;
  logic        w_wr_ctrl;
  logic        w_wr_preset;
  logic        w_unused;

  assign w_en        = r_ctrl[0];
  assign w_mode      = r_ctrl[2:1];
  assign w_im        = r_ctrl[3];
  assign w_ofs       = addr[3:2];
  assign w_wr_ctrl   = we && (w_ofs == OFS_CTRL);
  assign w_wr_preset = we && (w_ofs == OFS_PRESET);

  // The bridge confines accesses to the BASE_ADDR window, so only addr[3:2] matters.
  assign w_unused = ^{addr[31:4], addr[1:0], BASE_ADDR};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_ctrl     <= '0;
      r_preset   <= '0;
      r_count    <= '0;
      r_irq_flag <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_en) begin
            r_state    <= ST_LOAD;
            r_irq_flag <= 1'b0;
          end
        end
        ST_LOAD: begin
          r_count <= r_preset;
          r_state <= ST_CNT;
        end
        ST_CNT: begin
          if (!w_en) begin
            r_state <= ST_IDLE;
          end else if (r_count > 32'd1) begin
            r_count <= r_count - 32'd1;
          end else begin
            // PRESET of 0 lands here too, so it behaves like PRESET of 1.
            r_count    <= '0;
            r_irq_flag <= 1'b1;
            r_state    <= ST_INT;
          end
        end
        ST_INT: begin
          r_state <= ST_IDLE;
          if (w_mode == MODE_RELOAD) begin
            r_irq_flag <= 1'b0;
          end else begin
            r_ctrl[0] <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // NOTE: the bus write comes after the FSM on purpose; with non-blocking
      // assignments the last one in the block wins, so a CTRL write beats the
      // one-shot EN clear issued from INT in the same cycle.
      if (w_wr_ctrl) begin
        r_ctrl <= wdata[3:0];
      end
      if (w_wr_preset) begin
        r_preset <= wdata;
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (w_ofs)
      OFS_CTRL:   rdata = {28'd0, r_ctrl};
      OFS_PRESET: rdata = r_preset;
      OFS_COUNT:  rdata = r_count;
      default:    rdata = '0;
    endcase
  end

  assign irq = w_im & r_irq_flag;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: a per-edge vector table for the one-shot run,
// then hand-written sequences for reload, mask, mid-count edits and reset.
module tb_timer_counter;

  localparam logic [31:0] BASE = 32'h0000_7F00;
  localparam logic [1:0]  O_CTRL   = 2'd0;
  localparam logic [1:0]  O_PRESET = 2'd1;
  localparam logic [1:0]  O_COUNT  = 2'd2;
  localparam logic [1:0]  O_NONE   = 2'd3;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  timer_counter #(.BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  wofs;
    logic [31:0] wdat;
    logic [1:0]  rofs;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  function automatic logic [31:0] a(input logic [1:0] ofs);
    return BASE + {28'd0, ofs, 2'b00};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] ofs, input logic [31:0] data);
    addr  = a(ofs);
    wdata = data;
    we    = 1'b1;
    tick();
    we    = 1'b0;
    wdata = '0;
  endtask

  task automatic rd_check(input string name, input logic [1:0] ofs, input logic [31:0] exp);
    addr = a(ofs);
    #1;
    check(name, rdata, exp);
  endtask

  task automatic irq_check(input string name, input logic exp);
    check(name, {31'd0, irq}, {31'd0, exp});
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  vec_t vecs[16];

  initial begin
    int pulses;
    int m;
    logic [31:0] exp_cnt;

    reset = 1'b0;
    we    = 1'b0;
    addr  = a(O_CTRL);
    wdata = '0;

    // One-shot run with PRESET=5; each row is one clock edge.
    vecs[0]  = '{1'b1, O_PRESET, 32'd5,          O_PRESET, 32'd5,      1'b0};
    vecs[1]  = '{1'b1, O_CTRL,   32'hFFFF_FFF9,  O_CTRL,   32'h9,      1'b0}; // E0
    vecs[2]  = '{1'b0, O_CTRL,   32'd0,          O_COUNT,  32'd0,      1'b0}; // E1
    vecs[3]  = '{1'b0, O_CTRL,   32'd0,          O_COUNT,  32'd5,      1'b0}; // E2
    vecs[4]  = '{1'b1, O_COUNT,  32'h1234,       O_COUNT,  32'd4,      1'b0}; // E3
    vecs[5]  = '{1'b0, O_CTRL,   32'd0,          O_COUNT,  32'd3,      1'b0}; // E4
    vecs[6]  = '{1'b0, O_CTRL,   32'd0,          O_COUNT,  32'd2,      1'b0}; // E5
    vecs[7]  = '{1'b0, O_CTRL,   32'd0,          O_COUNT,  32'd1,      1'b0}; // E6
    vecs[8]  = '{1'b0, O_CTRL,   32'd0,          O_COUNT,  32'd0,      1'b1}; // E7
    vecs[9]  = '{1'b0, O_CTRL,   32'd0,          O_CTRL,   32'h8,      1'b1}; // E8
    vecs[10] = '{1'b0, O_CTRL,   32'd0,          O_NONE,   32'd0,      1'b1};
    vecs[11] = '{1'b1, O_CTRL,   32'h9,          O_CTRL,   32'h9,      1'b1};
    vecs[12] = '{1'b0, O_CTRL,   32'd0,          O_COUNT,  32'd0,      1'b0};
    vecs[13] = '{1'b1, O_CTRL,   32'h0,          O_COUNT,  32'd5,      1'b0};
    vecs[14] = '{1'b0, O_CTRL,   32'd0,          O_COUNT,  32'd5,      1'b0};
    vecs[15] = '{1'b0, O_CTRL,   32'd0,          O_CTRL,   32'h0,      1'b0};

    // Reset values.
    repeat (2) tick();
    reset = 1'b1;
    rd_check("rst_ctrl",   O_CTRL,   32'd0);
    rd_check("rst_preset", O_PRESET, 32'd0);
    rd_check("rst_count",  O_COUNT,  32'd0);
    rd_check("rst_ofs_c",  O_NONE,   32'd0);
    irq_check("rst_irq", 1'b0);

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].wr) begin
        bus_write(vecs[i].wofs, vecs[i].wdat);
      end else begin
        tick();
      end
      rd_check($sformatf("vec%0d_rdata", i), vecs[i].rofs, vecs[i].exp_rd);
      irq_check($sformatf("vec%0d_irq", i), vecs[i].exp_irq);
    end

    // Auto-reload, PRESET=3: period 6, irq pulse at E5, E11, E17.
    bus_write(O_PRESET, 32'd3);
    bus_write(O_CTRL, 32'hB);
    pulses = 0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      m = k % 6;
      case (m)
        1:       exp_cnt = (k == 1) ? 32'd5 : 32'd0;
        2:       exp_cnt = 32'd3;
        3:       exp_cnt = 32'd2;
        4:       exp_cnt = 32'd1;
        default: exp_cnt = 32'd0;
      endcase
      rd_check($sformatf("reload_count_k%0d", k), O_COUNT, exp_cnt);
      irq_check($sformatf("reload_irq_k%0d", k), (m == 5));
      if (irq) pulses++;
    end
    check("reload_pulses", pulses, 32'd3);
    rd_check("reload_ctrl", O_CTRL, 32'hB);

    // Masked: counter expires silently, unmasking later exposes the latched flag.
    apply_reset();
    bus_write(O_PRESET, 32'd2);
    bus_write(O_CTRL, 32'h1);
    for (int k = 1; k <= 6; k++) begin
      tick();
      irq_check($sformatf("mask_irq_k%0d", k), 1'b0);
      if (k == 4) rd_check("mask_count_e4", O_COUNT, 32'd0);
    end
    rd_check("mask_ctrl_cleared", O_CTRL, 32'h0);
    bus_write(O_CTRL, 32'h8);
    irq_check("unmask_irq", 1'b1);
    rd_check("unmask_ctrl", O_CTRL, 32'h8);

    // PRESET edit and disable mid-count.
    apply_reset();
    bus_write(O_PRESET, 32'd10);
    bus_write(O_CTRL, 32'h9);
    repeat (4) tick();
    rd_check("mid_count_e4", O_COUNT, 32'd8);
    addr  = a(O_PRESET);
    wdata = 32'd2;
    we    = 1'b1;
    #1;
    check("read_during_write_old", rdata, 32'd10);
    tick();
    we = 1'b0;
    rd_check("mid_preset_new", O_PRESET, 32'd2);
    rd_check("mid_count_e5", O_COUNT, 32'd7);
    tick();
    rd_check("mid_count_e6", O_COUNT, 32'd6);
    bus_write(O_CTRL, 32'h0);
    rd_check("dis_count_e7", O_COUNT, 32'd5);
    tick();
    rd_check("dis_count_e8", O_COUNT, 32'd5);
    tick();
    rd_check("dis_count_e9", O_COUNT, 32'd5);
    irq_check("dis_irq", 1'b0);
    bus_write(O_CTRL, 32'h9);
    repeat (2) tick();
    rd_check("newpreset_load", O_COUNT, 32'd2);
    tick();
    rd_check("newpreset_1", O_COUNT, 32'd1);
    irq_check("newpreset_irq_lo", 1'b0);
    tick();
    irq_check("newpreset_irq_hi", 1'b1);

    // PRESET=0 with MODE=10 (one-shot behaviour).
    apply_reset();
    bus_write(O_PRESET, 32'd0);
    bus_write(O_CTRL, 32'hD);
    tick();
    irq_check("p0_irq_e1", 1'b0);
    tick();
    rd_check("p0_count_e2", O_COUNT, 32'd0);
    irq_check("p0_irq_e2", 1'b0);
    tick();
    irq_check("p0_irq_e3", 1'b1);
    tick();
    rd_check("p0_ctrl_e4", O_CTRL, 32'hC);
    irq_check("p0_irq_e4", 1'b1);

    // CTRL write collides with the INT-state EN clear; the bus write wins.
    apply_reset();
    bus_write(O_PRESET, 32'd1);
    bus_write(O_CTRL, 32'h9);
    repeat (2) tick();
    rd_check("coll_count_e2", O_COUNT, 32'd1);
    tick();
    irq_check("coll_irq_e3", 1'b1);
    bus_write(O_CTRL, 32'h9);
    rd_check("coll_ctrl_e4", O_CTRL, 32'h9);
    irq_check("coll_irq_e4", 1'b1);
    tick();
    irq_check("coll_irq_e5", 1'b0);

    // Asynchronous reset in the middle of counting.
    apply_reset();
    bus_write(O_PRESET, 32'd10);
    bus_write(O_CTRL, 32'h9);
    repeat (5) tick();
    rd_check("areset_pre_count", O_COUNT, 32'd7);
    #2;
    reset = 1'b0;
    #1;
    rd_check("areset_count", O_COUNT, 32'd0);
    rd_check("areset_ctrl", O_CTRL, 32'd0);
    rd_check("areset_preset", O_PRESET, 32'd0);
    irq_check("areset_irq", 1'b0);
    tick();
    reset = 1'b1;
    repeat (3) tick();
    rd_check("post_count", O_COUNT, 32'd0);
    rd_check("post_ctrl", O_CTRL, 32'd0);
    irq_check("post_irq", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
